qmfir_uart_host: RTL and testbench
==================================

QMFIR_UART_HOST -- requirements
Module: qmfir_uart_host

Interface
REQ-001 Parameter TMO_CYC, default 65535: clk cycles allowed between read-response bytes before timeout.
REQ-002 clk  input  1  sole clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req_valid  input  1  host transaction request.
REQ-005 req_ready  output  1  high only in IDLE; request accepted when req_valid & req_ready.
REQ-006 req_wr  input  1  1 = write, 0 = read.
REQ-007 req_mem  input  1  1 = memory space, 0 = register space.
REQ-008 req_addr  input  14  target address.
REQ-009 req_wdata  input  32  write data, sent MSB byte first.
REQ-010 rsp_valid  output  1  one-cycle pulse at transaction completion.
REQ-011 rsp_err  output  1  valid with rsp_valid; 1 = read timeout.
REQ-012 rsp_rdata  output  24  read data, valid with rsp_valid.
REQ-013 tx_din  output  8  byte to UART TX FIFO.
REQ-014 tx_we  output  1  TX FIFO push strobe.
REQ-015 tx_full  input  1  TX FIFO full.
REQ-016 rx_dout  input  8  RX FIFO head byte, valid while rx_empty low (fall-through).
REQ-017 rx_re  output  1  RX FIFO pop strobe.
REQ-018 rx_empty  input  1  RX FIFO empty.

Function
REQ-019 Accept latches req_* into cmd[15:0] = {req_wr, req_mem, req_addr} and data[31:0]; inputs then ignored until IDLE.
REQ-020 States: IDLE, CMD1, CMD2, WD1, WD2, WD3, WD4, RD1, RD2, RD3, DONE.
REQ-021 IDLE -> CMD1 on accept; CMD1 sends cmd[15:8]; CMD2 sends cmd[7:0].
REQ-022 CMD2 -> WD1 if write, else RD1; WD1..WD4 send data[31:24], [23:16], [15:8], [7:0]; WD4 -> DONE.
REQ-023 Each send state asserts tx_we with its byte on tx_din only when tx_full low, advances the same cycle; tx_full high stalls the state with tx_we low.
REQ-024 RD1..RD3 pop one byte each (rx_re = ~rx_empty) into rsp_rdata[23:16], [15:8], [7:0]; advance on pop; RD3 -> DONE.
REQ-025 Timer resets to 0 on entry to each RD state and on each pop; counts while rx_empty; reaching TMO_CYC -> DONE with rsp_err=1, rsp_rdata=0.
REQ-026 DONE asserts rsp_valid for exactly one cycle, then -> IDLE; write completion has rsp_err=0, rsp_rdata=0.
REQ-027 In IDLE and all send states, non-empty RX FIFO is popped and discarded (stray bytes never reach rsp_rdata).
REQ-028 Outside RD states rx_re follows REQ-027 only; tx_we never asserted in IDLE, RD*, DONE.
REQ-029 Accept-to-first-tx_we latency 1 cycle; unstalled write is 6 consecutive tx_we, rsp_valid the cycle after the last.
REQ-030 req_valid while busy: no effect, no queuing.

Reset
REQ-031 rst high on any edge: state=IDLE, tx_we=0, rx_re=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, tx_din=0, timer=0, cmd/data=0; req_ready=1 the first cycle after rst deasserts.
REQ-032 rst mid-transaction abandons the frame with no rsp_valid; partially sent bytes are not retracted.

Structure
REQ-033 Package qmfir_uart_pkg holds the state enum, cmd bit positions (WR=15, MEM=14, ADDR=13:0), write/read frame byte counts (6/2 out, 0/3 in).
REQ-034 One sub-module, qmfir_uart_tmo: loadable clear/enable counter with terminal-count flag at TMO_CYC.

Verification
REQ-035 Write mem addr 0x0123 data 0xDEADBEEF, tx_full=0 -> tx bytes C1 23 DE AD BE EF on 6 consecutive cycles, then rsp_valid, rsp_err=0.
REQ-036 Read reg addr 0x0010, RX supplies 12 34 56 -> tx bytes 00 10, rsp_rdata=0x123456, rsp_err=0.
REQ-037 Write with tx_full high 3 cycles during WD2 -> byte 0xAD held, no duplicate/lost byte, order intact.
REQ-038 Read with TMO_CYC=16, only 1 response byte -> rsp_valid after 16 idle cycles, rsp_err=1, rsp_rdata=0, returns IDLE.
REQ-039 rst pulsed in WD3 -> no rsp_valid, req_ready=1 next cycle, new request completes correctly; stray RX byte in IDLE discarded.

Source files
------------

// File: rtl/qmfir_uart_pkg.sv
// Shared definitions for the UART host bridge: FSM states, command word
// layout and frame sizes.
package qmfir_uart_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_CMD1,
      ST_CMD2,
      ST_WD1,
      ST_WD2,
      ST_WD3,
      ST_WD4,
      ST_RD1,
      ST_RD2,
      ST_RD3,
      ST_DONE
   } state_e;

   // Command word: {wr, mem, addr[13:0]}
   localparam int CMD_WR      = 15;
   localparam int CMD_MEM     = 14;
   localparam int CMD_ADDR_HI = 13;
   localparam int CMD_ADDR_LO = 0;

   // Bytes per frame, host->device / device->host
   localparam int WR_TX_BYTES = 6;
   localparam int WR_RX_BYTES = 0;
   localparam int RD_TX_BYTES = 2;
   localparam int RD_RX_BYTES = 3;

endpackage

// File: rtl/qmfir_uart_tmo.sv
// Read-response timeout counter. tc_o fires on the enabled cycle that
// brings the count up to TMO_CYC.
module qmfir_uart_tmo #(
   parameter int unsigned TMO_CYC = 65535
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   localparam int unsigned W = (TMO_CYC < 2) ? 1 : $clog2(TMO_CYC + 1);

   logic [W-1:0] cnt_q, cnt_d;

   assign tc_o = en_i && (cnt_q == W'(TMO_CYC - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (en_i)
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/qmfir_uart_host.sv
// Host-side UART bridge: serialises a register/memory request into TX FIFO
// bytes and collects the 3-byte read response from the RX FIFO.
module qmfir_uart_host
   import qmfir_uart_pkg::*;
#(
   parameter int unsigned TMO_CYC = 65535
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wr,
   input  logic        req_mem,
   input  logic [13:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic        rsp_err,
   output logic [23:0] rsp_rdata,
   output logic [7:0]  tx_din,
   output logic        tx_we,
   input  logic        tx_full,
   input  logic [7:0]  rx_dout,
   output logic        rx_re,
   input  logic        rx_empty
);

   state_e      state_q, state_d;
   logic [15:0] cmd_q, cmd_d;
   logic [31:0] data_q, data_d;
   logic [23:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic        send, rd_st, tmo;
   logic [7:0]  tx_byte;

   assign send  = state_q inside {ST_CMD1, ST_CMD2, ST_WD1, ST_WD2, ST_WD3, ST_WD4};
   assign rd_st = state_q inside {ST_RD1, ST_RD2, ST_RD3};

   // Outside RD states any RX byte is stray and is drained; DONE leaves it queued.
   assign rx_re     = ~rst & ~rx_empty & (rd_st | send | (state_q == ST_IDLE));
   assign tx_we     = ~rst & send & ~tx_full;
   assign tx_din    = rst ? 8'h00 : tx_byte;
   assign req_ready = (state_q == ST_IDLE);
   assign rsp_valid = ~rst & (state_q == ST_DONE);
   assign rsp_err   = err_q;
   assign rsp_rdata = rdata_q;

   qmfir_uart_tmo #(.TMO_CYC(TMO_CYC)) u_tmo (
      .clk_i (clk),
      .rst_i (rst),
      .clr_i (~rd_st | ~rx_empty),
      .en_i  (rd_st & rx_empty),
      .tc_o  (tmo)
   );

   always_comb begin
      case (state_q)
         ST_CMD1: tx_byte = cmd_q[15:8];
         ST_CMD2: tx_byte = cmd_q[7:0];
         ST_WD1:  tx_byte = data_q[31:24];
         ST_WD2:  tx_byte = data_q[23:16];
         ST_WD3:  tx_byte = data_q[15:8];
         ST_WD4:  tx_byte = data_q[7:0];
         default: tx_byte = 8'h00;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cmd_d   = cmd_q;
      data_d  = data_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: if (req_valid) begin
            cmd_d   = {req_wr, req_mem, req_addr};
            data_d  = req_wdata;
            rdata_d = '0;
            err_d   = 1'b0;
            state_d = ST_CMD1;
         end
         ST_CMD1: if (!tx_full) state_d = ST_CMD2;
         ST_CMD2: if (!tx_full) state_d = cmd_q[CMD_WR] ? ST_WD1 : ST_RD1;
         ST_WD1:  if (!tx_full) state_d = ST_WD2;
         ST_WD2:  if (!tx_full) state_d = ST_WD3;
         ST_WD3:  if (!tx_full) state_d = ST_WD4;
         ST_WD4:  if (!tx_full) state_d = ST_DONE;
         ST_RD1, ST_RD2, ST_RD3: begin
            // Shift-in lands the first response byte in [23:16].
            if (!rx_empty) begin
               rdata_d = {rdata_q[15:0], rx_dout};
               state_d = (state_q == ST_RD1) ? ST_RD2 :
                         (state_q == ST_RD2) ? ST_RD3 : ST_DONE;
            end else if (tmo) begin
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cmd_q   <= '0;
         data_q  <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cmd_q   <= cmd_d;
         data_q  <= data_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_qmfir_uart_host.sv
// Directed bench for qmfir_uart_host with behavioural TX/RX FIFO ends.
module tb_qmfir_uart_host;

   localparam int TMO = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0, req_wr = 1'b0, req_mem = 1'b0;
   logic [13:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        req_ready, rsp_valid, rsp_err;
   logic [23:0] rsp_rdata;
   logic [7:0]  tx_din;
   logic        tx_we;
   logic        tx_full = 1'b0;
   logic [7:0]  rx_dout;
   logic        rx_re, rx_empty;

   int checks = 0, failures = 0;
   int cyc = 0;

   logic [7:0] rx_mem [0:63];
   logic [5:0] rx_wr = '0, rx_rd = '0;
   logic [7:0] tx_b [$];
   int         tx_c [$];
   int         rsp_n = 0, rsp_c = 0;
   logic       rsp_e;
   logic [23:0] rsp_d;

   qmfir_uart_host #(.TMO_CYC(TMO)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
      .req_mem(req_mem), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
      .tx_din(tx_din), .tx_we(tx_we), .tx_full(tx_full),
      .rx_dout(rx_dout), .rx_re(rx_re), .rx_empty(rx_empty)
   );

   always #5 clk = ~clk;

   assign rx_empty = (rx_rd == rx_wr);
   assign rx_dout  = rx_mem[rx_rd];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rx_re) rx_rd <= rx_rd + 6'd1;
   end

   always @(negedge clk) begin
      if (tx_we) begin
         tx_b.push_back(tx_din);
         tx_c.push_back(cyc);
      end
      if (rsp_valid) begin
         rsp_n++;
         rsp_c = cyc;
         rsp_e = rsp_err;
         rsp_d = rsp_rdata;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clr_log();
      tx_b.delete();
      tx_c.delete();
   endtask

   task automatic rx_push(input logic [7:0] b);
      rx_mem[rx_wr] = b;
      rx_wr = rx_wr + 6'd1;
   endtask

   task automatic do_req(input logic wr, input logic mem, input logic [13:0] addr,
                         input logic [31:0] wd, output int acc);
      req_valid = 1'b1; req_wr = wr; req_mem = mem; req_addr = addr; req_wdata = wd;
      tick(1);
      req_valid = 1'b0;
      acc = cyc;
   endtask

   task automatic wait_rsp(input int n0, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk); #1;
         if (rsp_n > n0) ok = 1'b1;
      end
      tick(1);
   endtask

   task automatic test_reset();
      rx_push(8'h5A);
      tick(2);
      @(negedge clk);
      checks++; if (tx_we !== 1'b0) begin failures++; $display("FAIL reset_tx_we got=%b exp=0", tx_we); end
      checks++; if (rx_re !== 1'b0) begin failures++; $display("FAIL reset_rx_re got=%b exp=0", rx_re); end
      checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
      checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL reset_rsp_err got=%b exp=0", rsp_err); end
      checks++; if (rsp_rdata !== 24'h0) begin failures++; $display("FAIL reset_rsp_rdata got=%h exp=0", rsp_rdata); end
      checks++; if (tx_din !== 8'h00) begin failures++; $display("FAIL reset_tx_din got=%h exp=00", tx_din); end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
      tick(1);
      checks++; if (rx_empty !== 1'b1) begin failures++; $display("FAIL reset_stray_drain got_empty=%b exp=1", rx_empty); end
      checks++; if (rsp_n !== 0) begin failures++; $display("FAIL reset_no_rsp got=%0d exp=0", rsp_n); end
   endtask

   task automatic test_write();
      logic [7:0] exp [6] = '{8'hC1, 8'h23, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
      int acc, n0; bit ok;
      clr_log(); n0 = rsp_n;
      do_req(1'b1, 1'b1, 14'h0123, 32'hDEADBEEF, acc);
      wait_rsp(n0, ok);
      checks++; if (!ok) begin failures++; $display("FAIL write_rsp timeout got=none exp=rsp_valid"); end
      checks++; if (tx_b.size() != 6) begin failures++; $display("FAIL write_nbytes got=%0d exp=6", tx_b.size()); end
      for (int i = 0; i < 6 && i < tx_b.size(); i++) begin
         checks++; if (tx_b[i] !== exp[i]) begin failures++; $display("FAIL write_byte%0d got=%h exp=%h", i, tx_b[i], exp[i]); end
         checks++; if (tx_c[i] != acc + i) begin failures++; $display("FAIL write_cyc%0d got=%0d exp=%0d", i, tx_c[i], acc + i); end
      end
      checks++; if (rsp_c != acc + 6) begin failures++; $display("FAIL write_rsp_cyc got=%0d exp=%0d", rsp_c, acc + 6); end
      checks++; if (rsp_e !== 1'b0) begin failures++; $display("FAIL write_err got=%b exp=0", rsp_e); end
      checks++; if (rsp_d !== 24'h0) begin failures++; $display("FAIL write_rdata got=%h exp=0", rsp_d); end
   endtask

   task automatic test_read();
      int acc, n0; bit ok;
      clr_log(); n0 = rsp_n;
      do_req(1'b0, 1'b0, 14'h0010, 32'h0, acc);
      tick(2);
      rx_push(8'h12); rx_push(8'h34); rx_push(8'h56);
      wait_rsp(n0, ok);
      checks++; if (!ok) begin failures++; $display("FAIL read_rsp timeout got=none exp=rsp_valid"); end
      checks++; if (tx_b.size() != 2) begin failures++; $display("FAIL read_nbytes got=%0d exp=2", tx_b.size()); end
      if (tx_b.size() == 2) begin
         checks++; if (tx_b[0] !== 8'h00 || tx_b[1] !== 8'h10) begin
            failures++; $display("FAIL read_cmd got=%h %h exp=00 10", tx_b[0], tx_b[1]); end
      end
      checks++; if (rsp_d !== 24'h123456) begin failures++; $display("FAIL read_rdata got=%h exp=123456", rsp_d); end
      checks++; if (rsp_e !== 1'b0) begin failures++; $display("FAIL read_err got=%b exp=0", rsp_e); end
   endtask

   task automatic test_tx_stall();
      logic [7:0] exp [6] = '{8'hAA, 8'hBC, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
      int expc [6];
      int acc, n0; bit ok;
      clr_log(); n0 = rsp_n;
      do_req(1'b1, 1'b0, 14'h2ABC, 32'hDEADBEEF, acc);
      expc = '{acc, acc + 1, acc + 2, acc + 6, acc + 7, acc + 8};
      tick(3);
      tx_full = 1'b1;
      tick(3);
      tx_full = 1'b0;
      wait_rsp(n0, ok);
      checks++; if (!ok) begin failures++; $display("FAIL stall_rsp timeout got=none exp=rsp_valid"); end
      checks++; if (tx_b.size() != 6) begin failures++; $display("FAIL stall_nbytes got=%0d exp=6", tx_b.size()); end
      for (int i = 0; i < 6 && i < tx_b.size(); i++) begin
         checks++; if (tx_b[i] !== exp[i]) begin failures++; $display("FAIL stall_byte%0d got=%h exp=%h", i, tx_b[i], exp[i]); end
         checks++; if (tx_c[i] != expc[i]) begin failures++; $display("FAIL stall_cyc%0d got=%0d exp=%0d", i, tx_c[i], expc[i]); end
      end
      checks++; if (rsp_c != acc + 9 || rsp_e !== 1'b0) begin
         failures++; $display("FAIL stall_rsp got_cyc=%0d err=%b exp_cyc=%0d err=0", rsp_c, rsp_e, acc + 9); end
   endtask

   task automatic test_timeout();
      int acc, n0; bit ok;
      clr_log(); n0 = rsp_n;
      do_req(1'b0, 1'b1, 14'h0200, 32'h0, acc);
      tick(2);
      rx_push(8'h77);
      wait_rsp(n0, ok);
      checks++; if (!ok) begin failures++; $display("FAIL tmo_rsp timeout got=none exp=rsp_valid"); end
      checks++; if (rsp_c != acc + 19) begin failures++; $display("FAIL tmo_cyc got=%0d exp=%0d", rsp_c, acc + 19); end
      checks++; if (rsp_e !== 1'b1) begin failures++; $display("FAIL tmo_err got=%b exp=1", rsp_e); end
      checks++; if (rsp_d !== 24'h0) begin failures++; $display("FAIL tmo_rdata got=%h exp=0", rsp_d); end
      checks++; if (tx_b.size() != 2 || (tx_b.size() == 2 && (tx_b[0] !== 8'h42 || tx_b[1] !== 8'h00))) begin
         failures++; $display("FAIL tmo_cmd got_n=%0d exp=2 bytes 42 00", tx_b.size()); end
      @(negedge clk);
      checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL tmo_idle got=%b exp=1", req_ready); end
   endtask

   task automatic test_busy();
      int acc, n0; bit ok;
      logic [7:0] exp [6] = '{8'hCA, 8'hBC, 8'h01, 8'h02, 8'h03, 8'h04};
      clr_log(); n0 = rsp_n;
      do_req(1'b1, 1'b1, 14'h0ABC, 32'h01020304, acc);
      req_valid = 1'b1; req_addr = 14'h0000; req_wdata = 32'hFFFFFFFF;
      tick(3);
      req_valid = 1'b0;
      wait_rsp(n0, ok);
      tick(10);
      checks++; if (!ok || rsp_n != n0 + 1) begin failures++; $display("FAIL busy_rsp_count got=%0d exp=%0d", rsp_n - n0, 1); end
      checks++; if (tx_b.size() != 6) begin failures++; $display("FAIL busy_nbytes got=%0d exp=6", tx_b.size()); end
      for (int i = 0; i < 6 && i < tx_b.size(); i++) begin
         checks++; if (tx_b[i] !== exp[i]) begin failures++; $display("FAIL busy_byte%0d got=%h exp=%h", i, tx_b[i], exp[i]); end
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] exp [4] = '{8'h80, 8'h01, 8'h11, 8'h22};
      int acc, n0; bit ok;
      clr_log(); n0 = rsp_n;
      do_req(1'b1, 1'b0, 14'h0001, 32'h11223344, acc);
      tick(4);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      @(negedge clk);
      checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rstmid_ready got=%b exp=1", req_ready); end
      rx_push(8'h99);
      tick(1);
      checks++; if (rx_empty !== 1'b1) begin failures++; $display("FAIL rstmid_stray got_empty=%b exp=1", rx_empty); end
      tick(5);
      checks++; if (rsp_n != n0) begin failures++; $display("FAIL rstmid_no_rsp got=%0d exp=%0d", rsp_n, n0); end
      checks++; if (tx_b.size() != 4) begin failures++; $display("FAIL rstmid_nbytes got=%0d exp=4", tx_b.size()); end
      for (int i = 0; i < 4 && i < tx_b.size(); i++) begin
         checks++; if (tx_b[i] !== exp[i]) begin failures++; $display("FAIL rstmid_byte%0d got=%h exp=%h", i, tx_b[i], exp[i]); end
      end
      clr_log(); n0 = rsp_n;
      do_req(1'b0, 1'b1, 14'h3FFF, 32'h0, acc);
      tick(2);
      rx_push(8'hAB); rx_push(8'hCD); rx_push(8'hEF);
      wait_rsp(n0, ok);
      checks++; if (!ok) begin failures++; $display("FAIL rstmid_new_rsp timeout got=none exp=rsp_valid"); end
      checks++; if (rsp_d !== 24'hABCDEF || rsp_e !== 1'b0) begin
         failures++; $display("FAIL rstmid_new_read got=%h err=%b exp=abcdef err=0", rsp_d, rsp_e); end
      checks++; if (tx_b.size() != 2 || (tx_b.size() == 2 && (tx_b[0] !== 8'h7F || tx_b[1] !== 8'hFF))) begin
         failures++; $display("FAIL rstmid_new_cmd got_n=%0d exp=2 bytes 7f ff", tx_b.size()); end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_write();
      test_read();
      test_tx_stall();
      test_timeout();
      test_busy();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
